voice_alloc: RTL and testbench
==============================

VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 16, giving the number of voice slots (2..256).
REQ-002 SHALL have port clk  input  1  system clock; the single clock of the block.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port midi_byte  input  8  received MIDI byte.
REQ-005 SHALL have port midi_valid  input  1  midi_byte is valid this cycle.
REQ-006 SHALL have port midi_ready  output  1  block accepts a byte this cycle; a transfer occurs when midi_valid and midi_ready are both high.
REQ-007 SHALL have ports note_pressed, note_released, note_keypress, pitch_wheel  output  1 each  single-cycle event strobes to the synth.
REQ-008 SHALL have ports note  output  7, velocity  output  7, channel  output  4  event payload.
REQ-009 SHALL have port addr  output  8  voice slot index for the event.

Function
REQ-010 SHALL parse status bytes 0x80-0xEF and hold them as running status; a data byte (bit7=0) with no running status SHALL be discarded.
REQ-011 SHALL ignore real-time bytes 0xF8-0xFF without altering parser state; 0xF0-0xF7 SHALL clear running status.
REQ-012 SHALL consume 0xB0/0xC0/0xD0-class messages (2/1/1 data bytes) and emit no event.
REQ-013 SHALL treat 0x9n with velocity 0 as note-off.
REQ-014 SHALL keep, per slot, registers valid, channel[3:0] and note[6:0].
REQ-015 Note-on: the hit slot (valid, same channel and note) SHALL be used first, else the lowest-index free slot, else the slot at steal_ptr; steal_ptr SHALL then increment modulo NUM_VOICES. The chosen slot SHALL be written valid with channel and note. note_pressed SHALL fire with addr=slot.
REQ-016 Note-off: for a hit slot, valid SHALL clear and note_released SHALL fire with addr=slot and the off velocity; on a miss, no strobe SHALL fire.
REQ-017 Poly aftertouch 0xAn: for a hit slot, note_keypress SHALL fire with velocity=pressure and addr=slot; a miss SHALL be dropped.
REQ-018 Pitch bend 0xEn: pitch_wheel SHALL fire with note=MSB data byte, velocity=LSB data byte, channel=n, addr=0.
REQ-019 Timing: with the final data byte accepted in cycle N, the slot lookup SHALL occur in cycle N+1 and the strobe plus payload SHALL be registered outputs valid in cycle N+2 only.
REQ-020 midi_ready SHALL be low in cycles N+1 and N+2 of every message that completes an event, and high otherwise.
REQ-021 Payload outputs SHALL hold their last values between strobes; at most one strobe SHALL be high per cycle.
REQ-022 Slot search SHALL be combinational priority logic over all slots within one cycle.

Reset
REQ-023 While rst is low: all strobes 0; note, velocity, channel, addr 0; every slot invalid; steal_ptr 0; running status cleared; parser idle; midi_ready 0.
REQ-024 midi_ready SHALL rise in the first clock after rst deasserts.
REQ-025 Reset mid-message SHALL discard any partial message and any pending strobe.

Structure
REQ-026 A shared package SHALL hold the MIDI status nibble constants (NOTE_OFF=8, NOTE_ON=9, POLY_AT=A, CC=B, PC=C, CH_AT=D, PITCH=E) and the parser state enumeration: IDLE, DATA1, DATA2, LOOKUP, EMIT.
REQ-027 Byte parsing SHALL be a sub-module midi_parser, which outputs a decoded message pulse; voice_alloc SHALL hold the slot table and the allocation logic.

Verification
REQ-028 Input 0x90 0x3C 0x64 -> note_pressed=1 for one cycle at N+2; note=0x3C, velocity=0x64, channel=0, addr=0.
REQ-029 Input 0x90 0x3C 0x64, then running-status bytes 0x40 0x50 and 0x3C 0x00 -> note_pressed with addr=1 for note 0x40, then note_released with addr=0 for note 0x3C.
REQ-030 NUM_VOICES=4; five distinct note-ons on channel 3 -> addr 0,1,2,3, then a steal at addr 0; a sixth note-on steals addr 1.
REQ-031 Input 0xE5 0x00 0x40, with 0xF8 inserted between the data bytes -> pitch_wheel=1, channel=5, note=0x40, velocity=0x00, addr=0.
REQ-032 Note-off 0x80 0x3C 0x00 for an unheld note -> no strobe; afterwards midi_ready is high and all slots are unchanged.
REQ-033 rst asserted at cycle N+1 of a note-on -> no note_pressed strobe and all slots invalid; a new note-on after reset gets addr=0.

Source files
------------

// File: rtl/voice_alloc_pkg.sv
// voice_alloc_pkg: shared MIDI constants, parser state encoding and the
// decoded-message record passed from the byte parser to the allocator.
package voice_alloc_pkg;

    // MIDI status high nibbles
    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_POLY_AT  = 4'hA;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [3:0] ST_PC       = 4'hC;
    localparam logic [3:0] ST_CH_AT    = 4'hD;
    localparam logic [3:0] ST_PITCH    = 4'hE;

    typedef enum logic [2:0] {IDLE, DATA1, DATA2, LOOKUP, EMIT} parse_state_e;

    typedef struct packed {
        logic [3:0] kind;   // status high nibble
        logic [3:0] chan;
        logic [6:0] d1;
        logic [6:0] d2;
    } midi_msg_t;

    // Program change and channel aftertouch carry a single data byte.
    function automatic logic two_data(input logic [3:0] kind);
        return !(kind == ST_PC || kind == ST_CH_AT);
    endfunction

endpackage

// File: rtl/voice_alloc_if.sv
// voice_alloc_if: MIDI byte stream in (valid/ready) and synth event bus out.
//   master: byte source / event sink (testbench or upstream UART side)
//   slave : voice_alloc
interface voice_alloc_if;
    logic [7:0] midi_byte;
    logic       midi_valid;
    logic       midi_ready;
    logic       note_pressed;
    logic       note_released;
    logic       note_keypress;
    logic       pitch_wheel;
    logic [6:0] note;
    logic [6:0] velocity;
    logic [3:0] channel;
    logic [7:0] addr;

    modport master (
        output midi_byte, midi_valid,
        input  midi_ready, note_pressed, note_released, note_keypress,
               pitch_wheel, note, velocity, channel, addr
    );

    modport slave (
        input  midi_byte, midi_valid,
        output midi_ready, note_pressed, note_released, note_keypress,
               pitch_wheel, note, velocity, channel, addr
    );
endinterface

// File: rtl/midi_parser.sv
// midi_parser: MIDI byte parser with running status.
//   clk, rst (async, active-low)
//   midi_byte/midi_valid/midi_ready : byte handshake
//   msg_valid : one-cycle pulse (the LOOKUP cycle) with msg holding the
//               decoded note/aftertouch/pitch message
// After an event-bearing message completes, ready drops for the LOOKUP and
// EMIT cycles so the allocator finishes before the next byte arrives.
module midi_parser
    import voice_alloc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] midi_byte,
    input  logic       midi_valid,
    output logic       midi_ready,
    output logic       msg_valid,
    output midi_msg_t  msg
);

    parse_state_e state_q;
    logic [7:0]   rs_q;     // running status byte, meaningful outside IDLE
    logic [6:0]   d1_q;
    logic [6:0]   d2_q;
    logic         ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rs_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                LOOKUP: state_q <= EMIT;
                EMIT: begin
                    state_q <= DATA1;   // running status survives the event
                    ready_q <= 1'b1;
                end
                default: begin
                    ready_q <= 1'b1;
                    if (midi_valid && ready_q) begin
                        if (midi_byte[7]) begin
                            // 0xF8-0xFF real-time: no effect on parser state
                            if (midi_byte < 8'hF0) begin
                                rs_q    <= midi_byte;
                                state_q <= DATA1;
                            end else if (midi_byte < 8'hF8) begin
                                state_q <= IDLE;
                            end
                        end else if (state_q == DATA1) begin
                            d1_q <= midi_byte[6:0];
                            // one-byte messages are consumed in place
                            if (two_data(rs_q[7:4])) state_q <= DATA2;
                        end else if (state_q == DATA2) begin
                            d2_q <= midi_byte[6:0];
                            if (rs_q[7:4] == ST_CC) begin
                                state_q <= DATA1;
                            end else begin
                                state_q <= LOOKUP;
                                ready_q <= 1'b0;
                            end
                        end
                        // data byte in IDLE: no running status, dropped
                    end
                end
            endcase
        end
    end

    assign midi_ready = ready_q;
    assign msg_valid  = (state_q == LOOKUP);
    assign msg        = {rs_q, d1_q, d2_q};

endmodule

// File: rtl/voice_alloc.sv
// voice_alloc: MIDI note to voice-slot allocator.
//   clk, rst (async, active-low)
//   bus (voice_alloc_if.slave): MIDI byte input and registered event strobes
//   with note/velocity/channel/addr payload.
// Slot search (hit, lowest free) is combinational over all slots during the
// parser's LOOKUP cycle; results land in the output registers one cycle later.
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 16
) (
    input  logic         clk,
    input  logic         rst,
    voice_alloc_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    midi_msg_t msg;
    logic      msg_valid;

    midi_parser u_parser (
        .clk        (clk),
        .rst        (rst),
        .midi_byte  (bus.midi_byte),
        .midi_valid (bus.midi_valid),
        .midi_ready (bus.midi_ready),
        .msg_valid  (msg_valid),
        .msg        (msg)
    );

    logic [NUM_VOICES-1:0]       vld_q, vld_d;
    logic [NUM_VOICES-1:0][3:0]  sch_q, sch_d;
    logic [NUM_VOICES-1:0][6:0]  snote_q, snote_d;
    logic [IDX_W-1:0]            steal_q, steal_d;
    logic [IDX_W-1:0]            hit_idx, free_idx, sel;
    logic                        hit, free;

    logic       pressed_q, pressed_d, released_q, released_d;
    logic       keypress_q, keypress_d, pitch_q, pitch_d;
    logic [6:0] note_q, note_d, vel_q, vel_d;
    logic [3:0] ch_q, ch_d;
    logic [7:0] addr_q, addr_d;

    // Priority search: walking downward lets the lowest index win.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (vld_q[i] && sch_q[i] == msg.chan && snote_q[i] == msg.d1) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!vld_q[i]) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign sel = hit ? hit_idx : (free ? free_idx : steal_q);

    always_comb begin
        vld_d      = vld_q;
        sch_d      = sch_q;
        snote_d    = snote_q;
        steal_d    = steal_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        keypress_d = 1'b0;
        pitch_d    = 1'b0;
        note_d     = note_q;
        vel_d      = vel_q;
        ch_d       = ch_q;
        addr_d     = addr_q;
        if (msg_valid) begin
            case (msg.kind)
                ST_NOTE_ON, ST_NOTE_OFF: begin
                    if (msg.kind == ST_NOTE_ON && msg.d2 != 7'd0) begin
                        vld_d[sel]   = 1'b1;
                        sch_d[sel]   = msg.chan;
                        snote_d[sel] = msg.d1;
                        // pointer only advances when a slot is actually stolen
                        if (!hit && !free)
                            steal_d = (steal_q == IDX_W'(NUM_VOICES - 1)) ? '0 : steal_q + 1'b1;
                        pressed_d = 1'b1;
                        note_d    = msg.d1;
                        vel_d     = msg.d2;
                        ch_d      = msg.chan;
                        addr_d    = 8'(sel);
                    end else if (hit) begin
                        vld_d[hit_idx] = 1'b0;
                        released_d     = 1'b1;
                        note_d         = msg.d1;
                        vel_d          = msg.d2;
                        ch_d           = msg.chan;
                        addr_d         = 8'(hit_idx);
                    end
                end
                ST_POLY_AT: begin
                    if (hit) begin
                        keypress_d = 1'b1;
                        note_d     = msg.d1;
                        vel_d      = msg.d2;
                        ch_d       = msg.chan;
                        addr_d     = 8'(hit_idx);
                    end
                end
                ST_PITCH: begin
                    pitch_d = 1'b1;
                    note_d  = msg.d2;   // MSB
                    vel_d   = msg.d1;   // LSB
                    ch_d    = msg.chan;
                    addr_d  = 8'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q      <= '0;
            sch_q      <= '0;
            snote_q    <= '0;
            steal_q    <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            keypress_q <= 1'b0;
            pitch_q    <= 1'b0;
            note_q     <= '0;
            vel_q      <= '0;
            ch_q       <= '0;
            addr_q     <= '0;
        end else begin
            vld_q      <= vld_d;
            sch_q      <= sch_d;
            snote_q    <= snote_d;
            steal_q    <= steal_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            keypress_q <= keypress_d;
            pitch_q    <= pitch_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            ch_q       <= ch_d;
            addr_q     <= addr_d;
        end
    end

    assign bus.note_pressed  = pressed_q;
    assign bus.note_released = released_q;
    assign bus.note_keypress = keypress_q;
    assign bus.pitch_wheel   = pitch_q;
    assign bus.note          = note_q;
    assign bus.velocity      = vel_q;
    assign bus.channel       = ch_q;
    assign bus.addr          = addr_q;

endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: directed MIDI streams into voice_alloc (4 voices); the
// stimulus pushes each expected event into a queue and a negedge monitor
// pops and compares whenever a strobe appears.
module tb_voice_alloc;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    voice_alloc_if bus ();

    voice_alloc #(.NUM_VOICES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // kind: 0 pressed, 1 released, 2 keypress, 3 pitch
    typedef struct {
        int kind;
        int note;
        int vel;
        int ch;
        int addr;
        int edge_n;
    } ev_t;

    ev_t exp_q[$];
    int  ecnt  = 0;
    int  acc   = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int budget = 0;
        bus.midi_byte  = b;
        bus.midi_valid = 1'b1;
        while (bus.midi_ready !== 1'b1 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 40) begin
            chk("ready_timeout", 0, 1);
            bus.midi_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.midi_valid = 1'b0;
        acc = ecnt;
    endtask

    // Strobe expected in cycle N+2: visible at the negedge after edge acc+1.
    task automatic push(input int kind, input int note, input int vel,
                        input int ch, input int addr);
        ev_t e;
        e.kind = kind; e.note = note; e.vel = vel;
        e.ch = ch; e.addr = addr; e.edge_n = acc + 1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin : mon
        int  k;
        int  got;
        ev_t e;
        k = int'(bus.note_pressed) + int'(bus.note_released)
          + int'(bus.note_keypress) + int'(bus.pitch_wheel);
        if (k > 1) chk("one_strobe", k, 1);
        if (k != 0) begin
            got = bus.note_pressed ? 0 : bus.note_released ? 1 : bus.note_keypress ? 2 : 3;
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe_kind", got, -1);
            end else begin
                e = exp_q.pop_front();
                chk("ev_kind",  got, e.kind);
                chk("ev_cycle", ecnt, e.edge_n);
                chk("ev_note",  int'(bus.note), e.note);
                chk("ev_vel",   int'(bus.velocity), e.vel);
                chk("ev_ch",    int'(bus.channel), e.ch);
                chk("ev_addr",  int'(bus.addr), e.addr);
            end
        end else if (exp_q.size() > 0 && exp_q[0].edge_n < ecnt) begin
            e = exp_q.pop_front();
            chk("missing_strobe_cycle", ecnt, e.edge_n);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.midi_byte  = 8'h00;
        bus.midi_valid = 1'b0;
        idle(3);
        chk("rst_ready",   int'(bus.midi_ready), 0);
        chk("rst_strobes", int'(bus.note_pressed) + int'(bus.note_released)
                         + int'(bus.note_keypress) + int'(bus.pitch_wheel), 0);
        chk("rst_note",    int'(bus.note), 0);
        chk("rst_vel",     int'(bus.velocity), 0);
        chk("rst_ch",      int'(bus.channel), 0);
        chk("rst_addr",    int'(bus.addr), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", int'(bus.midi_ready), 1);

        // Basic note-on, with ready/strobe timing around it
        send(8'h90); send(8'h3C); send(8'h64); push(0, 'h3C, 'h64, 0, 0);
        chk("ready_n1", int'(bus.midi_ready), 0);
        @(negedge clk);
        chk("ready_n2", int'(bus.midi_ready), 0);
        @(negedge clk);
        chk("ready_n3",    int'(bus.midi_ready), 1);
        chk("pulse_width", int'(bus.note_pressed), 0);
        chk("hold_note",   int'(bus.note), 'h3C);
        chk("hold_addr",   int'(bus.addr), 0);

        // Running status: next note-on then velocity-0 note-off
        send(8'h40); send(8'h50); push(0, 'h40, 'h50, 0, 1);
        send(8'h3C); send(8'h00); push(1, 'h3C, 0, 0, 0);

        // Note-off for an unheld note: no strobe
        send(8'h80); send(8'h3C); send(8'h00);
        idle(4);
        chk("ready_after_miss", int'(bus.midi_ready), 1);
        send(8'h40); send(8'h00); push(1, 'h40, 0, 0, 1);

        // Four slots fill, then steal at 0 and 1
        send(8'h93);
        for (int i = 0; i < 6; i++) begin
            send(8'(8'h10 + i)); send(8'(1 + i));
            push(0, 'h10 + i, 1 + i, 3, (i < 4) ? i : i - 4);
        end
        // Table: 0=14 1=15 2=12 3=13 (ch3)
        send(8'h12); send(8'h07); push(0, 'h12, 7, 3, 2);        // re-strike hit
        send(8'hA3); send(8'h13); send(8'h55); push(2, 'h13, 'h55, 3, 3);
        send(8'h7F); send(8'h01);                               // aftertouch miss
        send(8'h83); send(8'h14); send(8'h22); push(1, 'h14, 'h22, 3, 0);
        send(8'h93); send(8'h20); send(8'h09); push(0, 'h20, 9, 3, 0); // lowest free

        // Messages consumed without events; orphan data after 0xF0
        send(8'hB0); send(8'h07); send(8'h7F); send(8'h01); send(8'h02);
        send(8'hC0); send(8'h05); send(8'hD0); send(8'h10);
        send(8'hF0); send(8'h3C); send(8'h64); send(8'hF8);
        idle(4);
        chk("ready_after_nonevent", int'(bus.midi_ready), 1);

        // Pitch bend with a real-time byte between data bytes
        send(8'hE5); send(8'h00); send(8'hF8); send(8'h40); push(3, 'h40, 0, 5, 0);
        send(8'hF7); send(8'h40); send(8'h00);                  // status cleared
        idle(4);

        // Reset during the lookup cycle: no strobe, table wiped
        send(8'h90); send(8'h3C); send(8'h64);
        rst = 1'b0;
        idle(3);
        chk("rst_mid_ready", int'(bus.midi_ready), 0);
        chk("rst_mid_note",  int'(bus.note), 0);
        chk("rst_mid_addr",  int'(bus.addr), 0);
        rst = 1'b1;
        @(negedge clk);
        send(8'h90); send(8'h3C); send(8'h64); push(0, 'h3C, 'h64, 0, 0);
        send(8'h91); send(8'h3C); send(8'h10); push(0, 'h3C, 'h10, 1, 1);
        send(8'h81); send(8'h3C); send(8'h00); push(1, 'h3C, 0, 1, 1);
        idle(6);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
